// File: rtl/zigbee_rx_pkg.sv
// Shared receive-chain definitions: default sizes, phase type, FSM states.
// PHASE_LSB_DEG gives the angle of one phase LSB for stimulus generation.
package zigbee_rx_pkg;

   localparam int  W_SIZE        = 6;
   localparam int  SPC           = 4;
   localparam int  SR_LEN        = 32;
   localparam real PHASE_LSB_DEG = 5.625;

   typedef logic signed [W_SIZE-1:0] phase_t;

   typedef enum logic {
      WAIT_FIRST,
      RUN
   } pdiff_state_t;

endpackage

// File: rtl/zigbee_phase_delta.sv
// Wrapped phase difference: registered previous sample, combinational delta.
// Ports: clk, reset_n, load (capture win as prev), win, delta = win - prev.
module zigbee_phase_delta #(
   parameter int W_SIZE = zigbee_rx_pkg::W_SIZE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [W_SIZE-1:0] win,
   output logic [W_SIZE-1:0] delta
);

   logic [W_SIZE-1:0] prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= '0;
      end else if (load) begin
         prev <= win;
      end
   end

   // Modulo-2**W_SIZE subtraction is already the shortest signed path.
   assign delta = win - prev;

endmodule

// File: rtl/zigbee_phase_diff.sv
// FM discriminator: integrates wrapped phase deltas over SPC samples, slices chip.
// Ports: clk, reset_n, win, iValid, resync -> chip, chipSR (bit 0 newest), oValid.
module zigbee_phase_diff #(
   parameter int W_SIZE = zigbee_rx_pkg::W_SIZE,
   parameter int SPC    = zigbee_rx_pkg::SPC,
   parameter int SR_LEN = zigbee_rx_pkg::SR_LEN
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [W_SIZE-1:0] win,
   input  logic              iValid,
   input  logic              resync,
   output logic              chip,
   output logic [SR_LEN-1:0] chipSR,
   output logic              oValid
);

   import zigbee_rx_pkg::*;

   localparam int CW = $clog2(SPC);
   localparam int AW = W_SIZE + CW;

   pdiff_state_t      state, state_d;
   logic [AW-1:0]     acc, acc_d, dext, sum;
   logic [CW-1:0]     cnt, cnt_d;
   logic              chip_d, ov_d, load, chip_new;
   logic [SR_LEN-1:0] sr_d;
   logic [W_SIZE-1:0] delta;

   zigbee_phase_delta #(
      .W_SIZE (W_SIZE)
   ) u_delta (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .win     (win),
      .delta   (delta)
   );

   assign dext     = {{CW{delta[W_SIZE-1]}}, delta};
   assign sum      = acc + dext;
   // Sign slice; a zero sum counts as positive.
   assign chip_new = ~sum[AW-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= WAIT_FIRST;
         acc    <= '0;
         cnt    <= '0;
         chip   <= 1'b0;
         chipSR <= '0;
         oValid <= 1'b0;
      end else begin
         state  <= state_d;
         acc    <= acc_d;
         cnt    <= cnt_d;
         chip   <= chip_d;
         chipSR <= sr_d;
         oValid <= ov_d;
      end
   end

   always_comb begin
      state_d = state;
      acc_d   = acc;
      cnt_d   = cnt;
      chip_d  = chip;
      sr_d    = chipSR;
      ov_d    = 1'b0;
      load    = 1'b0;
      if (resync) begin
         // Restart chip timing; a coincident sample becomes the new first one.
         acc_d   = '0;
         cnt_d   = '0;
         load    = iValid;
         state_d = iValid ? RUN : WAIT_FIRST;
      end else if (iValid) begin
         load = 1'b1;
         unique case (state)
            WAIT_FIRST: begin
               state_d = RUN;
            end
            RUN: begin
               if (cnt == CW'(SPC - 1)) begin
                  chip_d = chip_new;
                  sr_d   = {chipSR[SR_LEN-2:0], chip_new};
                  ov_d   = 1'b1;
                  acc_d  = '0;
                  cnt_d  = '0;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zigbee_phase_diff.sv
// Self-checking bench for zigbee_phase_diff against an integer/real-angle model.
// Scenarios: ramps, wrap, alternating chips, gapped input, resync, async reset, random sweep.
module tb_zigbee_phase_diff;

   import zigbee_rx_pkg::*;

   logic              clk;
   logic              reset_n;
   logic [W_SIZE-1:0] win;
   logic              iValid;
   logic              resync;
   logic              chip;
   logic [SR_LEN-1:0] chipSR;
   logic              oValid;

   int checks;
   int failures;
   int cycle_no;

   // Model state
   bit                m_first;
   int                m_prev;
   int                m_sum;
   int                m_cnt;
   logic              m_chip;
   logic [SR_LEN-1:0] m_sr;
   logic              m_ov;

   zigbee_phase_diff #(
      .W_SIZE (W_SIZE),
      .SPC    (SPC),
      .SR_LEN (SR_LEN)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .win     (win),
      .iValid  (iValid),
      .resync  (resync),
      .chip    (chip),
      .chipSR  (chipSR),
      .oValid  (oValid)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cycle_no <= cycle_no + 1;

   function automatic phase_t ph(input int x);
      logic [31:0] t;
      t = x;
      return phase_t'(t[W_SIZE-1:0]);
   endfunction

   // Shortest signed angular distance in LSBs.
   function automatic int wrapd(input int d);
      int r;
      r = d;
      while (r >= (1 << (W_SIZE - 1))) r = r - (1 << W_SIZE);
      while (r < -(1 << (W_SIZE - 1))) r = r + (1 << W_SIZE);
      return r;
   endfunction

   task automatic model_reset();
      m_first = 1'b1;
      m_prev  = 0;
      m_sum   = 0;
      m_cnt   = 0;
      m_chip  = 1'b0;
      m_sr    = '0;
      m_ov    = 1'b0;
   endtask

   task automatic model_step(input bit v, input int w, input bit rs);
      int p;
      p    = int'(ph(w));
      m_ov = 1'b0;
      if (rs) begin
         m_sum = 0;
         m_cnt = 0;
         if (v) begin
            m_prev  = p;
            m_first = 1'b0;
         end else begin
            m_first = 1'b1;
         end
      end else if (v) begin
         if (m_first) begin
            m_first = 1'b0;
         end else begin
            m_sum = m_sum + wrapd(p - m_prev);
            m_cnt = m_cnt + 1;
            if (m_cnt == SPC) begin
               m_chip = (m_sum >= 0);
               m_sr   = {m_sr[SR_LEN-2:0], m_chip};
               m_ov   = 1'b1;
               m_sum  = 0;
               m_cnt  = 0;
            end
         end
         m_prev = p;
      end
   endtask

   // Drive one clock of stimulus, then advance the model past that edge.
   task automatic cyc(input bit v, input int w, input bit rs);
      @(negedge clk);
      iValid = v;
      win    = ph(w);
      resync = rs;
      @(posedge clk);
      #1;
      model_step(v, w, rs);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      iValid  = 1'b0;
      resync  = 1'b0;
      win     = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({oValid, chip, chipSR} !== '0) begin
         failures++;
         $display("FAIL reset got=%h exp=0", {oValid, chip, chipSR});
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_ramp_up();
      for (int i = 0; i < 13; i++) begin
         cyc(1'b1, 2 * i, 1'b0);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL ramp_up i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
         if (i == 4) begin
            checks++;
            if (oValid !== 1'b1 || chip !== 1'b1) begin
               failures++;
               $display("FAIL ramp_up_first_strobe got=%b%b exp=11", oValid, chip);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int seq_a[5];
      int seq_b[5];
      seq_a = '{28, -28, -20, -12, -4};
      seq_b = '{31, -32, -31, -30, -29};
      cyc(1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, seq_a[i], 1'b0);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL wrap_a i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
      end
      checks++;
      if (oValid !== 1'b1 || chip !== 1'b1) begin
         failures++;
         $display("FAIL wrap_a_chip got=%b%b exp=11", oValid, chip);
      end
      cyc(1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, seq_b[i], 1'b0);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL wrap_b i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
      end
      checks++;
      if (oValid !== 1'b1 || chip !== 1'b1) begin
         failures++;
         $display("FAIL wrap_b_chip got=%b%b exp=11", oValid, chip);
      end
   endtask

   task automatic test_ramp_down_alt();
      int p;
      cyc(1'b0, 0, 1'b1);
      p = 5;
      cyc(1'b1, p, 1'b0);
      for (int i = 0; i < 4; i++) begin
         p = p - 3;
         cyc(1'b1, p, 1'b0);
      end
      checks++;
      if (oValid !== 1'b1 || chip !== 1'b0) begin
         failures++;
         $display("FAIL ramp_down_chip got=%b%b exp=10", oValid, chip);
      end
      cyc(1'b1, p, 1'b1);
      for (int c = 0; c < 32; c++) begin
         for (int s = 0; s < SPC; s++) begin
            p = p + ((c % 2 == 0) ? 3 : -3);
            cyc(1'b1, p, 1'b0);
            checks++;
            if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
               failures++;
               $display("FAIL alt c=%0d s=%0d got=%h exp=%h", c, s,
                        {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
            end
         end
      end
      checks++;
      if (chipSR !== 32'hAAAA_AAAA) begin
         failures++;
         $display("FAIL alt_pattern got=%h exp=aaaaaaaa", chipSR);
      end
   endtask

   task automatic test_gapped();
      int p;
      int last;
      int nstrobe;
      p       = 0;
      last    = 0;
      nstrobe = 0;
      cyc(1'b0, 0, 1'b1);
      for (int i = 0; i < 65; i++) begin
         if (i % 5 == 0) begin
            cyc(1'b1, p, 1'b0);
            p = p + 1;
         end else begin
            cyc(1'b0, 0, 1'b0);
         end
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL gapped i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
         if (oValid === 1'b1) begin
            if (nstrobe > 0) begin
               checks++;
               if (i - last != 20) begin
                  failures++;
                  $display("FAIL gapped_spacing got=%0d exp=20", i - last);
               end
            end
            nstrobe++;
            last = i;
         end
      end
      checks++;
      if (nstrobe != 3) begin
         failures++;
         $display("FAIL gapped_count got=%0d exp=3", nstrobe);
      end
   endtask

   task automatic test_resync();
      logic [SR_LEN-1:0] sr0;
      int                first_ov;
      cyc(1'b0, 0, 1'b1);
      cyc(1'b1, 0, 1'b0);
      cyc(1'b1, -10, 1'b0);
      cyc(1'b1, -20, 1'b0);
      sr0 = chipSR;
      cyc(1'b1, 7, 1'b1);
      first_ov = -1;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 7 + 2 * (i + 1), 1'b0);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL resync i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
         if (oValid === 1'b1 && first_ov < 0) first_ov = i;
         if (i < 3) begin
            checks++;
            if (chipSR !== sr0) begin
               failures++;
               $display("FAIL resync_hold got=%h exp=%h", chipSR, sr0);
            end
         end
      end
      checks++;
      if (first_ov != 3) begin
         failures++;
         $display("FAIL resync_latency got=%0d exp=3", first_ov);
      end
   endtask

   task automatic test_async_reset();
      cyc(1'b0, 0, 1'b1);
      for (int i = 0; i < 7; i++) cyc(1'b1, 4 * i, 1'b0);
      checks++;
      if (chipSR === '0) begin
         failures++;
         $display("FAIL areset_pre got=%h exp=nonzero", chipSR);
      end
      #4;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({oValid, chip, chipSR} !== '0) begin
         failures++;
         $display("FAIL areset_now got=%h exp=0", {oValid, chip, chipSR});
      end
      iValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 2 * i, 1'b0);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL areset_after i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
      end
   endtask

   // Random frequency sweep quantised from a real-valued angle.
   task automatic test_random();
      real ang;
      real step;
      int  k;
      bit  v;
      bit  rs;
      ang  = 0.0;
      step = 20.0;
      for (int i = 0; i < 600; i++) begin
         if (i % 16 == 0)
            step = real'($urandom_range(0, 1200)) / 10.0 - 60.0;
         v  = ($urandom_range(0, 9) < 7);
         rs = ($urandom_range(0, 99) < 3);
         if (v) begin
            ang = ang + step;
            while (ang >= 180.0) ang = ang - 360.0;
            while (ang < -180.0) ang = ang + 360.0;
         end
         k = $rtoi(ang / PHASE_LSB_DEG + ((ang >= 0.0) ? 0.5 : -0.5));
         cyc(v, k, rs);
         checks++;
         if ({oValid, chip, chipSR} !== {m_ov, m_chip, m_sr}) begin
            failures++;
            $display("FAIL random i=%0d got=%h exp=%h", i,
                     {oValid, chip, chipSR}, {m_ov, m_chip, m_sr});
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cycle_no = 0;
      test_reset();
      test_ramp_up();
      test_wrap();
      test_ramp_down_alt();
      test_gapped();
      test_resync();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
